clint_timer_ipi: RTL and testbench

- Core-local interruptor that generates the per-hart timer and software (inter-processor) interrupt lines, `time_irq` and `ipi`, consumed by the core top-level.
- Holds a 64-bit mtime counter advanced by an external real-time-clock tick.
- Holds one 64-bit mtimecmp and one msip bit per hart.
- Registers are reached over a simple req/gnt/rvalid register port, which is bridged from the core's memory-side bus.

---
 rtl/clint_timer_ipi.sv | 93 +++++++++
 tb/tb_clint_timer_ipi.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clint_timer_ipi.sv
// clint_timer_ipi: per-hart timer and software interrupt generator with an RTC-driven 64-bit mtime
// and a single-cycle req/gnt/rvalid register port.
module clint_timer_ipi #(
   parameter int NrHarts   = 1,
   parameter int AddrWidth = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rtc_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [63:0]          wdata_i,
   input  logic [7:0]           be_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   output logic [63:0]          rdata_o,
   output logic                 err_o,
   output logic [NrHarts-1:0]   timer_irq_o,
   output logic [NrHarts-1:0]   ipi_o
);
   logic s1, s2, prev, tick;
   logic [63:0] mtime, mtime_n, bm, rd;
   logic [63:0] cmp [NrHarts];
   logic [63:0] cmp_n [NrHarts];
   logic [NrHarts-1:0] msip, msip_n, irq_n;
   logic [31:0] wa, ci, lo;
   logic is_mtime, is_cmp, is_msip, err_c, wr;
   assign gnt_o = req_i;
   assign tick = s2 & ~prev;
   assign wa = 32'({addr_i[AddrWidth-1:3], 3'b000});
   assign is_mtime = wa == 32'hBFF8;
   assign is_cmp = wa >= 32'h4000 && wa < 32'hBFF8;
   assign is_msip = wa < 32'h4000;
   assign ci = (wa - 32'h4000) >> 3;
   // msip word k covers harts 2k and 2k+1, so the lower hart index is the byte address / 4
   assign lo = wa >> 2;
   assign err_c = req_i & ~(is_mtime | (is_cmp & (ci < 32'(NrHarts))) | (is_msip & (lo < 32'(NrHarts))));
   assign wr = req_i & we_i & ~err_c;
   always_comb begin
      for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{be_i[i]}};
      mtime_n = tick ? mtime + 64'd1 : mtime;
      cmp_n = cmp;
      msip_n = msip;
      rd = '0;
      if (is_mtime) begin
         rd = mtime;
         if (wr) mtime_n = (mtime & ~bm) | (wdata_i & bm);
      end
      for (int h = 0; h < NrHarts; h++) begin
         if (is_cmp && ci == 32'(h)) begin
            rd = cmp[h];
            if (wr) cmp_n[h] = (cmp[h] & ~bm) | (wdata_i & bm);
         end
         if (is_msip && lo == 32'(h)) begin
            rd[0] = msip[h];
            if (wr && be_i[0]) msip_n[h] = wdata_i[0];
         end
         if (is_msip && lo + 32'd1 == 32'(h)) begin
            rd[32] = msip[h];
            if (wr && be_i[4]) msip_n[h] = wdata_i[32];
         end
         irq_n[h] = mtime_n >= cmp_n[h];
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         prev <= 1'b0;
         mtime <= '0;
         cmp <= '{default: '1};
         msip <= '0;
         rvalid_o <= 1'b0;
         rdata_o <= '0;
         err_o <= 1'b0;
         timer_irq_o <= '0;
         ipi_o <= '0;
      end else begin
         s1 <= rtc_i;
         s2 <= s1;
         prev <= s2;
         mtime <= mtime_n;
         cmp <= cmp_n;
         msip <= msip_n;
         rvalid_o <= req_i;
         err_o <= err_c;
         if (req_i) rdata_o <= (we_i | err_c) ? '0 : rd;
         timer_irq_o <= irq_n;
         ipi_o <= msip_n;
      end
   end
endmodule

// File: tb/tb_clint_timer_ipi.sv
// tb_clint_timer_ipi: directed and randomized checks of clint_timer_ipi against a register-level model.
module tb_clint_timer_ipi;
   localparam int NH = 3;
   logic clk_i = 1'b0, rst_i = 1'b1, rtc_i = 1'b0, req_i = 1'b0, we_i = 1'b0;
   logic [15:0] addr_i = '0;
   logic [63:0] wdata_i = '0;
   logic [7:0] be_i = '0;
   logic gnt_o, rvalid_o, err_o;
   logic [63:0] rdata_o;
   logic [NH-1:0] timer_irq_o, ipi_o;
   clint_timer_ipi #(.NrHarts(NH), .AddrWidth(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .rtc_i(rtc_i), .req_i(req_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .timer_irq_o(timer_irq_o), .ipi_o(ipi_o));
   always #5 clk_i = ~clk_i;
   int n_vec = 0, n_err = 0;
   logic [63:0] m_time, m_rdata;
   logic [63:0] m_cmp [NH];
   logic [NH-1:0] m_msip, m_irq;
   logic m_rvalid, m_err, rtc_prev, r1, r2, rtc_lv = 1'b0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic m_reset();
      m_time = '0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
      m_msip = '0;
      m_irq = '0;
      m_rvalid = 1'b0;
      m_rdata = '0;
      m_err = 1'b0;
      rtc_prev = 1'b0;
      r1 = 1'b0;
      r2 = 1'b0;
   endtask
   task automatic cycle(input logic rq, input logic w, input logic [15:0] a, input logic [63:0] d,
                        input logic [7:0] b, input logic rtc);
      logic inc, ok, wr;
      logic [15:0] wa;
      logic [63:0] rd, mk;
      int idx;
      @(negedge clk_i);
      req_i = rq; we_i = w; addr_i = a; wdata_i = d; be_i = b; rtc_i = rtc;
      #1 chk("gnt", 64'(gnt_o), 64'(rq));
      inc = r2;
      r2 = r1;
      r1 = rtc & ~rtc_prev;
      rtc_prev = rtc;
      wa = a & 16'hFFF8;
      rd = '0;
      idx = 0;
      if (wa == 16'hBFF8) begin
         ok = 1'b1;
         rd = m_time;
      end else if (wa >= 16'h4000) begin
         idx = (int'(wa) - 'h4000) / 8;
         ok = idx < NH;
         if (ok) rd = m_cmp[idx];
      end else begin
         idx = int'(wa) / 4;
         ok = idx < NH;
         if (ok) rd[0] = m_msip[idx];
         if (idx + 1 < NH) rd[32] = m_msip[idx+1];
      end
      for (int i = 0; i < 8; i++) mk[8*i +: 8] = {8{b[i]}};
      m_rvalid = rq;
      m_err = rq & ~ok;
      if (rq) m_rdata = (w || !ok) ? 64'd0 : rd;
      wr = rq && w && ok;
      if (wr && wa == 16'hBFF8) m_time = (m_time & ~mk) | (d & mk);
      else if (inc) m_time = m_time + 64'd1;
      if (wr && wa >= 16'h4000 && wa != 16'hBFF8) m_cmp[idx] = (m_cmp[idx] & ~mk) | (d & mk);
      if (wr && wa < 16'h4000) begin
         if (b[0]) m_msip[idx] = d[0];
         if (b[4] && idx + 1 < NH) m_msip[idx+1] = d[32];
      end
      for (int h = 0; h < NH; h++) m_irq[h] = m_time >= m_cmp[h];
      @(posedge clk_i);
      #1;
      chk("rvalid", 64'(rvalid_o), 64'(m_rvalid));
      if (m_rvalid) chk("err", 64'(err_o), 64'(m_err));
      chk("rdata", rdata_o, m_rdata);
      chk("timer_irq", 64'(timer_irq_o), 64'(m_irq));
      chk("ipi", 64'(ipi_o), 64'(m_msip));
   endtask
   task automatic op(input logic w, input logic [15:0] a, input logic [63:0] d, input logic [7:0] b);
      cycle(1'b1, w, a, d, b, rtc_lv);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 64'h0, 8'h0, rtc_lv);
   endtask
   task automatic ticks(input int n, input int half);
      for (int i = 0; i < n; i++) begin
         rtc_lv = 1'b1;
         idle(half);
         rtc_lv = 1'b0;
         idle(half);
      end
   endtask
   task automatic do_reset(input bit mid);
      @(negedge clk_i);
      rtc_i = 1'b0;
      rtc_lv = 1'b0;
      if (mid) begin
         req_i = 1'b1; we_i = 1'b0; addr_i = 16'hBFF8;
      end
      #2 rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      m_reset();
      chk("rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_rdata", rdata_o, 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_irq", 64'(timer_irq_o), 64'd0);
      chk("rst_ipi", 64'(ipi_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      req_i = 1'b0;
      @(posedge clk_i);
      #1 chk("post_rst_rvalid", 64'(rvalid_o), 64'd0);
   endtask
   initial begin
      logic [15:0] pool [10];
      logic [63:0] d;
      logic [15:0] a;
      pool = '{16'h0000, 16'h0008, 16'h0010, 16'h4000, 16'h4008, 16'h4010, 16'h4018, 16'h8000, 16'hBFF8, 16'hC000};
      do_reset(1'b0);
      op(1'b0, 16'hBFF8, 64'h0, 8'h00);
      chk("rst_mtime", rdata_o, 64'd0);
      chk("rst_err0", 64'(err_o), 64'd0);
      op(1'b0, 16'h4000, 64'h0, 8'h00);
      chk("rst_cmp", rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
      ticks(5, 5);
      op(1'b0, 16'hBFF8, 64'h0, 8'h00);
      chk("mtime5", rdata_o, 64'd5);
      op(1'b1, 16'hBFF8, 64'd0, 8'hFF);
      op(1'b1, 16'h4000, 64'd3, 8'hFF);
      ticks(3, 2);
      idle(3);
      chk("irq_set", 64'(timer_irq_o[0]), 64'd1);
      op(1'b1, 16'h4000, 64'd100, 8'hFF);
      chk("irq_clr", 64'(timer_irq_o[0]), 64'd0);
      op(1'b1, 16'h0000, 64'h1_0000_0000, 8'hF0);
      chk("ipi_hi", 64'(ipi_o), 64'b010);
      op(1'b1, 16'h0000, 64'h0, 8'h0F);
      chk("ipi_hold", 64'(ipi_o), 64'b010);
      op(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      ticks(1, 3);
      idle(2);
      op(1'b0, 16'hBFF8, 64'h0, 8'h00);
      chk("wrap", rdata_o, 64'd0);
      rtc_lv = 1'b1;
      idle(2);
      op(1'b1, 16'hBFF8, 64'd42, 8'hFF);
      rtc_lv = 1'b0;
      idle(3);
      op(1'b0, 16'hBFF8, 64'h0, 8'h00);
      chk("wr_wins", rdata_o, 64'd42);
      op(1'b0, 16'h8000, 64'h0, 8'h00);
      chk("err_8000", 64'(err_o), 64'd1);
      chk("err_rdata", rdata_o, 64'd0);
      op(1'b1, 16'h4018, 64'd7, 8'hFF);
      chk("err_4018", 64'(err_o), 64'd1);
      op(1'b1, 16'h0010, 64'h1, 8'hFF);
      op(1'b0, 16'h4000, 64'h0, 8'h00);
      chk("cmp_kept", rdata_o, 64'd100);
      op(1'b0, 16'h0008, 64'h0, 8'h00);
      chk("msip_w1_err", 64'(err_o), 64'd0);
      do_reset(1'b1);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) rtc_lv = ~rtc_lv;
         a = pool[$urandom_range(0, 9)] | 16'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) a = 16'($urandom);
         d = $urandom_range(0, 1) ? m_time + 64'($urandom_range(0, 8)) - 64'd4 : {$urandom, $urandom};
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d,
               $urandom_range(0, 1) ? 8'hFF : 8'($urandom), rtc_lv);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
